// File: rtl/score_keeper_if.sv
// Goal, serve-control and score signals between ball physics,
// the score keeper and the game-state/display logic.
interface score_keeper_if #(
   parameter int SCORE_W = 4
);
   logic               clk_1ms;
   logic               p1_goal;
   logic               p2_goal;
   logic               new_game;
   logic [SCORE_W-1:0] p1_score;
   logic [SCORE_W-1:0] p2_score;
   logic               ball_hold;
   logic               serve_dir;
   logic               point;

   // physics / game-control side
   modport master (
      output clk_1ms, p1_goal, p2_goal, new_game,
      input  p1_score, p2_score, ball_hold, serve_dir, point
   );

   // score keeper side
   modport slave (
      input  clk_1ms, p1_goal, p2_goal, new_game,
      output p1_score, p2_score, ball_hold, serve_dir, point
   );
endinterface

// File: rtl/score_keeper.sv
// Score keeper: turns goal-line crossings into saturating per-player scores,
// holds the ball for a serve delay after each goal and freezes play once a
// player reaches WIN_SCORE.
//
// state | meaning
// ------+-------------------------------------------------------------
// SERVE | ball held centred; counting clk_1ms ticks of the serve delay
// PLAY  | ball live; first clean goal edge scores and ends the rally
// OVER  | a player reached WIN_SCORE; everything frozen until new_game
//
// WIN_SCORE must fit in SCORE_W bits (WIN_SCORE <= 2**SCORE_W - 1).
module score_keeper #(
   parameter int WIN_SCORE = 5,
   parameter int PAUSE_MS  = 1000,
   parameter int SCORE_W   = 4
) (
   input  logic         clk,
   input  logic         reset,
   score_keeper_if.slave bus
);

   localparam int                 CNT_W     = $clog2(PAUSE_MS) + 1;
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PAUSE_MS - 1);
   localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);

   typedef enum logic [1:0] {
      SERVE = 2'd0,
      PLAY  = 2'd1,
      OVER  = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [SCORE_W-1:0] p1_score_r, p1_score_nxt;
   logic [SCORE_W-1:0] p2_score_r, p2_score_nxt;
   logic               serve_dir_r, serve_dir_nxt;
   logic               point_r, point_nxt;

   logic               clk_1ms_q;
   logic               p1_goal_q;
   logic               p2_goal_q;
   logic               tick;
   logic               g1;
   logic               g2;

   // History registers; reset to 1 so levels already high at release
   // do not look like fresh rising edges.
   always_ff @(posedge clk) begin
      if (!reset) begin
         clk_1ms_q <= 1'b1;
         p1_goal_q <= 1'b1;
         p2_goal_q <= 1'b1;
      end else begin
         clk_1ms_q <= bus.clk_1ms;
         p1_goal_q <= bus.p1_goal;
         p2_goal_q <= bus.p2_goal;
      end
   end

   assign tick = bus.clk_1ms & ~clk_1ms_q;
   assign g1   = bus.p1_goal & ~p1_goal_q;
   assign g2   = bus.p2_goal & ~p2_goal_q;

   // Next-state, serve-delay counter and score update.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      p1_score_nxt  = p1_score_r;
      p2_score_nxt  = p2_score_r;
      serve_dir_nxt = serve_dir_r;
      point_nxt     = 1'b0;

      if (bus.new_game) begin
         state_nxt     = SERVE;
         cnt_nxt       = '0;
         p1_score_nxt  = '0;
         p2_score_nxt  = '0;
         serve_dir_nxt = 1'b0;
      end else begin
         case (state)
            SERVE: begin
               if (tick) begin
                  if (cnt == CNT_LAST) begin
                     cnt_nxt   = '0;
                     state_nxt = PLAY;
                  end else begin
                     cnt_nxt = cnt + 1'b1;
                  end
               end
            end

            PLAY: begin
               // Simultaneous edges on both lines are ambiguous and dropped.
               if (g1 && !g2) begin
                  p1_score_nxt = p1_score_r + 1'b1;
                  point_nxt    = 1'b1;
                  if (p1_score_nxt == SCORE_WIN) begin
                     state_nxt = OVER;
                  end else begin
                     state_nxt     = SERVE;
                     serve_dir_nxt = 1'b1;
                  end
               end else if (g2 && !g1) begin
                  p2_score_nxt = p2_score_r + 1'b1;
                  point_nxt    = 1'b1;
                  if (p2_score_nxt == SCORE_WIN) begin
                     state_nxt = OVER;
                  end else begin
                     state_nxt     = SERVE;
                     serve_dir_nxt = 1'b0;
                  end
               end
            end

            OVER: begin
               cnt_nxt = '0;
            end

            default: begin
               state_nxt = SERVE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= SERVE;
         cnt         <= '0;
         p1_score_r  <= '0;
         p2_score_r  <= '0;
         serve_dir_r <= 1'b0;
         point_r     <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         p1_score_r  <= p1_score_nxt;
         p2_score_r  <= p2_score_nxt;
         serve_dir_r <= serve_dir_nxt;
         point_r     <= point_nxt;
      end
   end

   assign bus.p1_score  = p1_score_r;
   assign bus.p2_score  = p2_score_r;
   assign bus.serve_dir = serve_dir_r;
   assign bus.point     = point_r;
   assign bus.ball_hold = (state != PLAY);

endmodule
